// File: rtl/apb_ctrl_pkg.sv
// apb_ctrl_pkg: shared FSM state type and default timeout for the APB master
package apb_ctrl_pkg;
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
   localparam int TIMEOUT_DEF = 16;
endpackage

// File: rtl/apb_master_arb_if.sv
// apb_master_arb_if: APB bus signals between the arbitrating master and a slave
interface apb_master_arb_if #(
   parameter int AW = 32,
   parameter int DW = 32
) ();
   logic          PSEL;
   logic          PENABLE;
   logic          PWRITE;
   logic [AW-1:0] PADDR;
   logic [DW-1:0] PWDATA;
   logic [DW-1:0] PRDATA;
   logic          PREADY;
   modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA, input PRDATA, PREADY);
   modport slave  (input PSEL, PENABLE, PWRITE, PADDR, PWDATA, output PRDATA, PREADY);
endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin pick favouring the requester not granted last
module rr_arb2 (
   input  logic [1:0] req_i,
   input  logic       last_i,
   input  logic       en_i,
   output logic [1:0] gnt_o
);
   assign gnt_o[0] = en_i & req_i[0] & (~req_i[1] | last_i);
   assign gnt_o[1] = en_i & req_i[1] & (~req_i[0] | ~last_i);
endmodule

// File: rtl/apb_master_arb.sv
// apb_master_arb: two-requester round-robin APB master with wait-state timeout
module apb_master_arb
   import apb_ctrl_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int AW      = 32,
   parameter int DW      = 32
) (
   input  logic             PCLK,
   input  logic             PRESETn,
   input  logic [1:0]       req_i,
   input  logic [1:0]       req_we_i,
   input  logic [2*AW-1:0]  req_addr_i,
   input  logic [2*DW-1:0]  req_wdata_i,
   output logic [1:0]       gnt_o,
   output logic [1:0]       done_o,
   output logic             err_o,
   output logic [DW-1:0]    rdata_o,
   apb_master_arb_if.master apb
);
   state_t        state_q, state_d;
   logic          psel_q, psel_d, pen_q, pen_d, pwrite_q, pwrite_d;
   logic          last_q, last_d, err_q, err_d;
   logic [1:0]    done_q, done_d, gnt;
   logic [AW-1:0] paddr_q, paddr_d;
   logic [DW-1:0] pwdata_q, pwdata_d, rdata_q, rdata_d;
   logic [7:0]    cnt_q, cnt_d;
   logic          fin, tout;
   rr_arb2 u_arb (
      .req_i  (req_i),
      .last_i (last_q),
      .en_i   (state_q == IDLE && PRESETn),
      .gnt_o  (gnt)
   );
   assign fin  = state_q == ACCESS && apb.PREADY;
   assign tout = state_q == ACCESS && !apb.PREADY && cnt_q == 8'(TIMEOUT - 1);
   // Next state: capture the winner in IDLE, one SETUP cycle, then wait in ACCESS for PREADY or timeout
   always_comb begin
      state_d  = (state_q == IDLE) ? ((|gnt) ? SETUP : IDLE) :
                 (state_q == SETUP) ? ACCESS : (fin || tout) ? IDLE : ACCESS;
      psel_d   = state_d != IDLE;
      pen_d    = state_d == ACCESS;
      pwrite_d = (|gnt) ? req_we_i[gnt[1]] : pwrite_q;
      paddr_d  = (|gnt) ? (gnt[1] ? req_addr_i[2*AW-1:AW] : req_addr_i[AW-1:0]) : paddr_q;
      pwdata_d = (|gnt) ? (gnt[1] ? req_wdata_i[2*DW-1:DW] : req_wdata_i[DW-1:0]) : pwdata_q;
      last_d   = (|gnt) ? gnt[1] : last_q;
      cnt_d    = (|gnt) ? 8'd0 : (state_q == ACCESS && !apb.PREADY) ? cnt_q + 8'd1 : cnt_q;
      done_d   = (fin || tout) ? (last_q ? 2'b10 : 2'b01) : 2'b00;
      err_d    = tout;
      rdata_d  = (fin && !pwrite_q) ? apb.PRDATA : rdata_q;
   end
   // State and registered outputs; reset returns to idle with requester 0 favoured
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q  <= IDLE;
         psel_q   <= 1'b0;
         pen_q    <= 1'b0;
         pwrite_q <= 1'b0;
         paddr_q  <= '0;
         pwdata_q <= '0;
         last_q   <= 1'b1;
         cnt_q    <= '0;
         done_q   <= '0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         psel_q   <= psel_d;
         pen_q    <= pen_d;
         pwrite_q <= pwrite_d;
         paddr_q  <= paddr_d;
         pwdata_q <= pwdata_d;
         last_q   <= last_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
      end
   end
   assign apb.PSEL    = psel_q;
   assign apb.PENABLE = pen_q;
   assign apb.PWRITE  = pwrite_q;
   assign apb.PADDR   = paddr_q;
   assign apb.PWDATA  = pwdata_q;
   assign gnt_o       = gnt;
   assign done_o      = done_q;
   assign err_o       = err_q;
   assign rdata_o     = rdata_q;
endmodule

// File: tb/tb_apb_master_arb.sv
// tb_apb_master_arb: scenario tasks with a completion scoreboard against a wait-state APB slave
module tb_apb_master_arb;
   localparam int AW = 32;
   localparam int DW = 32;
   logic          PCLK = 1'b0;
   logic          PRESETn = 1'b0;
   logic [1:0]    req_i = '0, req_we_i = '0;
   logic [63:0]   req_addr_i = '0, req_wdata_i = '0;
   logic [1:0]    gnt_o, done_o;
   logic          err_o;
   logic [31:0]   rdata_o;
   apb_master_arb_if #(.AW(AW), .DW(DW)) bus ();
   apb_master_arb #(.TIMEOUT(16), .AW(AW), .DW(DW)) dut (
      .PCLK        (PCLK),
      .PRESETn     (PRESETn),
      .req_i       (req_i),
      .req_we_i    (req_we_i),
      .req_addr_i  (req_addr_i),
      .req_wdata_i (req_wdata_i),
      .gnt_o       (gnt_o),
      .done_o      (done_o),
      .err_o       (err_o),
      .rdata_o     (rdata_o),
      .apb         (bus)
   );
   always #5 PCLK = ~PCLK;
   typedef struct {logic [1:0] done; logic err; logic [31:0] rdata;} exp_t;
   exp_t        sb[$];
   int          checks = 0, errors = 0;
   logic [31:0] rd_key = 32'hF0F0_FF36;
   logic [31:0] exp_rd = '0;
   logic        tb_last = 1'b1;
   logic        stuck = 1'b0;
   int          wait_n = 0;
   int          acc_n;
   // Slave: PREADY after wait_n wait cycles in ACCESS, read data derived from the address
   always @(posedge PCLK or negedge PRESETn)
      if (!PRESETn) acc_n <= 0;
      else acc_n <= (bus.PSEL && bus.PENABLE && !bus.PREADY) ? acc_n + 1 : 0;
   assign bus.PREADY = bus.PSEL && bus.PENABLE && !stuck && acc_n >= wait_n;
   assign bus.PRDATA = bus.PADDR ^ rd_key;

   task automatic issue(input int r, input logic we, input logic [31:0] a, input logic [31:0] wd);
      req_i[r] = 1'b1;
      req_we_i[r] = we;
      req_addr_i[r*32 +: 32] = a;
      req_wdata_i[r*32 +: 32] = wd;
   endtask

   task automatic wait_done(input int budget, output int cyc, output int nacc, output logic [1:0] d,
                            output logic e, output logic [31:0] rd, output logic ps);
      cyc = 0; nacc = 0; d = '0; e = 1'b0; rd = '0; ps = 1'b0;
      while (cyc < budget && d == 2'b00) begin
         @(negedge PCLK);
         cyc++;
         if (bus.PSEL && bus.PENABLE) nacc++;
         d = done_o; e = err_o; rd = rdata_o; ps = bus.PSEL;
      end
   endtask

   task automatic test_reset();
      req_i = 2'b11;
      #12;
      checks++;
      if ({bus.PSEL, bus.PENABLE, bus.PWRITE} !== 3'b000 || bus.PADDR !== '0 || bus.PWDATA !== '0) begin
         errors++; $display("FAIL reset_bus: got sel/en/wr=%b%b%b addr=%h wdata=%h exp all zero", bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA);
      end
      checks++;
      if (gnt_o !== 2'b00 || done_o !== 2'b00 || err_o !== 1'b0 || rdata_o !== '0) begin
         errors++; $display("FAIL reset_out: got gnt=%b done=%b err=%b rdata=%h exp all zero", gnt_o, done_o, err_o, rdata_o);
      end
      @(negedge PCLK);
      req_i = 2'b00;
      PRESETn = 1'b1;
   endtask

   task automatic test_write();
      exp_t x;
      @(negedge PCLK);
      issue(0, 1'b1, 32'hFFFF_0F0F, 32'h0000_00C9);
      #1;
      checks++;
      if (gnt_o !== 2'b01) begin errors++; $display("FAIL write_gnt: got %b exp 01", gnt_o); end
      x = '{done: 2'b01, err: 1'b0, rdata: exp_rd};
      sb.push_back(x);
      tb_last = 1'b0;
      @(negedge PCLK);
      checks++;
      if ({bus.PSEL, bus.PENABLE, bus.PWRITE} !== 3'b101 || bus.PADDR !== 32'hFFFF_0F0F || bus.PWDATA !== 32'hC9 || gnt_o !== 2'b00) begin
         errors++; $display("FAIL write_setup: got sel/en/wr=%b%b%b addr=%h wdata=%h gnt=%b exp 101 ffff0f0f c9 00", bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA, gnt_o);
      end
      req_i = 2'b00; req_we_i = 2'b00; req_addr_i = {32'h0, 32'h1234_5678}; req_wdata_i = '0;
      @(negedge PCLK);
      checks++;
      if ({bus.PSEL, bus.PENABLE, bus.PWRITE} !== 3'b111 || bus.PADDR !== 32'hFFFF_0F0F || bus.PWDATA !== 32'hC9 || done_o !== 2'b00) begin
         errors++; $display("FAIL write_access: got sel/en/wr=%b%b%b addr=%h wdata=%h done=%b exp 111 ffff0f0f c9 00", bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA, done_o);
      end
      @(negedge PCLK);
      x = sb.pop_front();
      checks++;
      if (done_o !== x.done || err_o !== x.err || rdata_o !== x.rdata) begin
         errors++; $display("FAIL write_done: got done=%b err=%b rdata=%h exp %b %b %h", done_o, err_o, rdata_o, x.done, x.err, x.rdata);
      end
      checks++;
      if (bus.PSEL !== 1'b0 || bus.PENABLE !== 1'b0) begin
         errors++; $display("FAIL write_idle: got sel/en=%b%b exp 00", bus.PSEL, bus.PENABLE);
      end
   endtask

   task automatic test_read();
      exp_t x; int cyc, nacc; logic [1:0] d; logic e, ps; logic [31:0] rd;
      @(negedge PCLK);
      issue(1, 1'b0, 32'hF0F0_FFFF, 32'h0);
      #1;
      checks++;
      if (gnt_o !== 2'b10) begin errors++; $display("FAIL read_gnt: got %b exp 10", gnt_o); end
      exp_rd = 32'h0000_00C9;
      x = '{done: 2'b10, err: 1'b0, rdata: exp_rd};
      sb.push_back(x);
      tb_last = 1'b1;
      @(posedge PCLK); #1 req_i = 2'b00;
      wait_done(10, cyc, nacc, d, e, rd, ps);
      x = sb.pop_front();
      checks++;
      if (cyc !== 3) begin errors++; $display("FAIL read_latency: got %0d exp 3", cyc); end
      checks++;
      if (d !== x.done || e !== x.err || rd !== x.rdata) begin
         errors++; $display("FAIL read_done: got done=%b err=%b rdata=%h exp %b %b %h", d, e, rd, x.done, x.err, x.rdata);
      end
      @(negedge PCLK);
      issue(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
      x = '{done: 2'b01, err: 1'b0, rdata: exp_rd};
      sb.push_back(x);
      tb_last = 1'b0;
      @(posedge PCLK); #1 req_i = 2'b00;
      wait_done(10, cyc, nacc, d, e, rd, ps);
      x = sb.pop_front();
      checks++;
      if (d !== x.done || e !== x.err || rd !== x.rdata) begin
         errors++; $display("FAIL write_keeps_rdata: got done=%b err=%b rdata=%h exp %b %b %h", d, e, rd, x.done, x.err, x.rdata);
      end
      repeat (3) @(negedge PCLK);
      checks++;
      if (rdata_o !== exp_rd) begin errors++; $display("FAIL rdata_hold: got %h exp %h", rdata_o, exp_rd); end
   endtask

   task automatic test_contention();
      exp_t x; int cyc, nacc; logic [1:0] d, eg; logic e, ps; logic [31:0] rd;
      @(negedge PCLK);
      req_we_i = 2'b01;
      req_addr_i = {32'h0000_0200, 32'h0000_0100};
      req_wdata_i = {32'h0, 32'h0000_00AA};
      req_i = 2'b11;
      #1;
      for (int k = 0; k < 4; k++) begin
         eg = tb_last ? 2'b01 : 2'b10;
         checks++;
         if (gnt_o !== eg) begin errors++; $display("FAIL contend_gnt%0d: got %b exp %b", k, gnt_o, eg); end
         if (eg[1]) exp_rd = 32'h0000_0200 ^ rd_key;
         x = '{done: eg, err: 1'b0, rdata: exp_rd};
         sb.push_back(x);
         tb_last = eg[1];
         wait_done(10, cyc, nacc, d, e, rd, ps);
         x = sb.pop_front();
         checks++;
         if (cyc !== 3 || d !== x.done || e !== x.err || rd !== x.rdata) begin
            errors++; $display("FAIL contend_done%0d: got cyc=%0d done=%b err=%b rdata=%h exp 3 %b %b %h", k, cyc, d, e, rd, x.done, x.err, x.rdata);
         end
      end
      req_i = 2'b00;
   endtask

   task automatic test_wait();
      exp_t x; int cyc, nacc; logic [1:0] d; logic e, ps; logic [31:0] rd;
      @(negedge PCLK);
      wait_n = 3;
      issue(0, 1'b0, 32'h0000_0040, 32'h0);
      #1;
      checks++;
      if (gnt_o !== 2'b01) begin errors++; $display("FAIL wait_gnt: got %b exp 01", gnt_o); end
      exp_rd = 32'h0000_0040 ^ rd_key;
      x = '{done: 2'b01, err: 1'b0, rdata: exp_rd};
      sb.push_back(x);
      tb_last = 1'b0;
      @(posedge PCLK); #1 req_i = 2'b00;
      wait_done(20, cyc, nacc, d, e, rd, ps);
      x = sb.pop_front();
      checks++;
      if (nacc !== 4 || cyc !== 6) begin errors++; $display("FAIL wait_cycles: got access=%0d total=%0d exp 4 6", nacc, cyc); end
      checks++;
      if (d !== x.done || e !== x.err || rd !== x.rdata) begin
         errors++; $display("FAIL wait_done: got done=%b err=%b rdata=%h exp %b %b %h", d, e, rd, x.done, x.err, x.rdata);
      end
      wait_n = 0;
   endtask

   task automatic test_timeout();
      exp_t x; int cyc, nacc; logic [1:0] d; logic e, ps; logic [31:0] rd;
      @(negedge PCLK);
      stuck = 1'b1;
      issue(1, 1'b0, 32'h0000_0080, 32'h0);
      #1;
      checks++;
      if (gnt_o !== 2'b10) begin errors++; $display("FAIL tout_gnt: got %b exp 10", gnt_o); end
      x = '{done: 2'b10, err: 1'b1, rdata: exp_rd};
      sb.push_back(x);
      tb_last = 1'b1;
      @(posedge PCLK); #1 req_i = 2'b00;
      wait_done(40, cyc, nacc, d, e, rd, ps);
      x = sb.pop_front();
      checks++;
      if (nacc !== 16 || cyc !== 18) begin errors++; $display("FAIL tout_cycles: got access=%0d total=%0d exp 16 18", nacc, cyc); end
      checks++;
      if (d !== x.done || e !== x.err || rd !== x.rdata) begin
         errors++; $display("FAIL tout_done: got done=%b err=%b rdata=%h exp %b %b %h", d, e, rd, x.done, x.err, x.rdata);
      end
      checks++;
      if (ps !== 1'b0) begin errors++; $display("FAIL tout_idle: got psel=%b exp 0", ps); end
      stuck = 1'b0;
   endtask

   task automatic test_timeout_edge();
      exp_t x; int cyc, nacc; logic [1:0] d; logic e, ps; logic [31:0] rd;
      @(negedge PCLK);
      wait_n = 15;
      issue(0, 1'b0, 32'h0000_0044, 32'h0);
      exp_rd = 32'h0000_0044 ^ rd_key;
      x = '{done: 2'b01, err: 1'b0, rdata: exp_rd};
      sb.push_back(x);
      tb_last = 1'b0;
      @(posedge PCLK); #1 req_i = 2'b00;
      wait_done(40, cyc, nacc, d, e, rd, ps);
      x = sb.pop_front();
      checks++;
      if (nacc !== 16) begin errors++; $display("FAIL edge_cycles: got access=%0d exp 16", nacc); end
      checks++;
      if (d !== x.done || e !== x.err || rd !== x.rdata) begin
         errors++; $display("FAIL edge_done: got done=%b err=%b rdata=%h exp %b %b %h", d, e, rd, x.done, x.err, x.rdata);
      end
      wait_n = 0;
   endtask

   task automatic test_reset_mid();
      exp_t x; int cyc, nacc; logic [1:0] d; logic e, ps; logic [31:0] rd; int seen;
      @(negedge PCLK);
      stuck = 1'b1;
      issue(1, 1'b1, 32'h0000_0048, 32'h0000_5555);
      x = '{done: 2'b10, err: 1'b1, rdata: exp_rd};
      sb.push_back(x);
      @(posedge PCLK); #1 req_i = 2'b00;
      repeat (2) @(negedge PCLK);
      checks++;
      if (bus.PENABLE !== 1'b1) begin errors++; $display("FAIL rst_pre_access: got en=%b exp 1", bus.PENABLE); end
      #2 PRESETn = 1'b0;
      #1;
      sb.delete();
      exp_rd = '0;
      tb_last = 1'b1;
      checks++;
      if ({bus.PSEL, bus.PENABLE, bus.PWRITE} !== 3'b000 || bus.PADDR !== '0 || bus.PWDATA !== '0 || done_o !== 2'b00 || err_o !== 1'b0 || rdata_o !== '0) begin
         errors++; $display("FAIL rst_async: got sel/en/wr=%b%b%b addr=%h wdata=%h done=%b err=%b rdata=%h exp all zero", bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA, done_o, err_o, rdata_o);
      end
      seen = 0;
      repeat (3) begin
         @(negedge PCLK);
         if (done_o !== 2'b00) seen++;
      end
      PRESETn = 1'b1;
      stuck = 1'b0;
      @(negedge PCLK);
      if (done_o !== 2'b00) seen++;
      checks++;
      if (seen !== 0) begin errors++; $display("FAIL rst_no_done: got %0d done pulses exp 0", seen); end
      req_we_i = 2'b00;
      req_addr_i = {32'h0000_0050, 32'h0000_004C};
      req_i = 2'b11;
      #1;
      checks++;
      if (gnt_o !== 2'b01) begin errors++; $display("FAIL rst_first_gnt: got %b exp 01", gnt_o); end
      exp_rd = 32'h0000_004C ^ rd_key;
      x = '{done: 2'b01, err: 1'b0, rdata: exp_rd};
      sb.push_back(x);
      tb_last = 1'b0;
      @(posedge PCLK); #1 req_i = 2'b00;
      wait_done(10, cyc, nacc, d, e, rd, ps);
      x = sb.pop_front();
      checks++;
      if (cyc !== 3 || d !== x.done || e !== x.err || rd !== x.rdata) begin
         errors++; $display("FAIL rst_after_done: got cyc=%0d done=%b err=%b rdata=%h exp 3 %b %b %h", cyc, d, e, rd, x.done, x.err, x.rdata);
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_contention();
      test_wait();
      test_timeout();
      test_timeout_edge();
      test_reset_mid();
      repeat (2) @(negedge PCLK);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
